// File: rtl/vend_dispatch_ctrl.sv
// vend_dispatch_ctrl
//
// Sequences a completed purchase onto the machine's actuators: checks and
// decrements per-product stock, runs the dispense motor through a req/ack
// handshake with a timeout, then pays out the due amount one coin at a time
// (greedy: value-2 coins while at least 2 remain, then a value-1 coin).
// Completion is reported with a one-cycle done pulse and a status code.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   req_valid/req_ready    purchase handshake (ready only while idle)
//   req_prod               product code: 01 A, 10 B, 11 C, 00 none
//   req_cambio             change due when the product is delivered
//   req_pago               amount paid, refunded on stock-out or motor fault
//   restock                reload every stock counter (honoured only while idle)
//   disp_req/disp_prod     dispense-motor request and product
//   disp_ack               motor delivered the product (pulse)
//   pay_req/pay_coin       hopper coin request; pay_coin 1 = value 2, 0 = value 1
//   pay_ack                hopper ejected the requested coin (pulse)
//   done/status            completion pulse; 00 ok, 01 stock-out, 10 motor fault
//   stock                  stock counts, A in the low field, then B, then C
module vend_dispatch_ctrl #(
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 5,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_prod,
    input  logic [4:0]           req_cambio,
    input  logic [4:0]           req_pago,
    input  logic                 restock,
    output logic                 disp_req,
    output logic [1:0]           disp_prod,
    input  logic                 disp_ack,
    output logic                 pay_req,
    output logic                 pay_coin,
    input  logic                 pay_ack,
    output logic                 done,
    output logic [1:0]           status,
    output logic [3*STOCK_W-1:0] stock
);

    localparam int unsigned        TimerW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 1);
    localparam logic [TimerW-1:0]  TimerOne  = TimerW'(1);
    localparam logic [STOCK_W-1:0] StockInit = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0] StockOne  = STOCK_W'(1);

    localparam logic [1:0] StatOk       = 2'b00;
    localparam logic [1:0] StatAgotado  = 2'b01;
    localparam logic [1:0] StatFault    = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StDisp,
        StPayout,
        StDone
    } state_e;

    state_e                      state_q;
    logic [1:0]                  prod_q;
    logic [4:0]                  cambio_q;
    logic [4:0]                  pago_q;
    logic [4:0]                  amt_q;
    logic [1:0]                  stat_q;
    logic [TimerW-1:0]           timer_q;
    logic [2:0][STOCK_W-1:0]     stock_q;

    // Product codes 01..11 map onto stock fields 0..2.
    logic [1:0] req_idx;
    logic [1:0] prod_idx;
    assign req_idx  = req_prod - 2'd1;
    assign prod_idx = prod_q - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            prod_q   <= 2'b00;
            cambio_q <= '0;
            pago_q   <= '0;
            amt_q    <= '0;
            stat_q   <= StatOk;
            timer_q  <= '0;
            stock_q  <= {3{StockInit}};
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Restock overrides the counters; the stock check below
                    // still sees the pre-restock values.
                    if (restock) begin
                        stock_q <= {3{StockInit}};
                    end
                    if (req_valid) begin
                        prod_q   <= req_prod;
                        cambio_q <= req_cambio;
                        pago_q   <= req_pago;
                        if (req_prod != 2'b00) begin
                            if (stock_q[req_idx] == '0) begin
                                amt_q   <= req_pago;
                                stat_q  <= StatAgotado;
                                state_q <= StPayout;
                            end else begin
                                timer_q <= '0;
                                state_q <= StDisp;
                            end
                        end
                    end
                end
                StDisp: begin
                    if (disp_ack) begin
                        // Entry to DISP required stock > 0, so no underflow.
                        stock_q[prod_idx] <= stock_q[prod_idx] - StockOne;
                        amt_q   <= cambio_q;
                        stat_q  <= StatOk;
                        state_q <= StPayout;
                    end else if (timer_q == TimerLast) begin
                        amt_q   <= pago_q;
                        stat_q  <= StatFault;
                        state_q <= StPayout;
                    end else begin
                        timer_q <= timer_q + TimerOne;
                    end
                end
                StPayout: begin
                    if (amt_q == '0) begin
                        state_q <= StDone;
                    end else if (pay_ack) begin
                        amt_q <= amt_q - ((amt_q >= 5'd2) ? 5'd2 : 5'd1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode only registered state, never the inputs.
    assign req_ready = (state_q == StIdle);
    assign disp_req  = (state_q == StDisp);
    assign disp_prod = disp_req ? prod_q : 2'b00;
    assign pay_req   = (state_q == StPayout) && (amt_q != '0);
    assign pay_coin  = pay_req && (amt_q >= 5'd2);
    assign done      = (state_q == StDone);
    assign status    = done ? stat_q : StatOk;
    assign stock     = stock_q;

endmodule
